// File: rtl/misao_xmem_unit.sv
`default_nettype none
// ============================================================================
// Module   : misao_xmem_unit
// Purpose  : XMEM load/store unit for the MISA-O core. Holds NUM_RA address
//            registers and moves nibble, byte or multi-byte little-endian
//            data over a byte-wide memory bus, one byte per cycle, with
//            optional post-increment/decrement of the selected register.
// Ports    : clk, rst (sync, active-low)
//            req_*            request channel from execute (ready = IDLE)
//            rdata/done/err   load result, completion and bad-index pulses
//            ra_wr_*          external address-register write port
//            ra_q             all address registers, RA0 in the LSBs
//            mem_*            byte-wide shared memory bus
// Revision : 1.0 - initial release
// ============================================================================
module misao_xmem_unit #(
   parameter int ADDR_W     = 15,
   parameter int DATA_BYTES = 2,
   parameter int NUM_RA     = 2,
   localparam int RAW       = (NUM_RA > 1) ? $clog2(NUM_RA) : 1,
   localparam int DW        = 8 * DATA_BYTES
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic                     req_store,
   input  logic [1:0]               req_size,
   input  logic [RAW-1:0]           req_ra_sel,
   input  logic [1:0]               req_step,
   input  logic [DW-1:0]            req_wdata,
   output logic [DW-1:0]            rdata,
   output logic                     done,
   output logic                     err,
   input  logic                     ra_wr_en,
   input  logic [RAW-1:0]           ra_wr_sel,
   input  logic [ADDR_W-1:0]        ra_wr_data,
   output logic [NUM_RA*ADDR_W-1:0] ra_q,
   output logic                     mem_enable_read,
   output logic                     mem_enable_write,
   output logic                     mem_rw,
   output logic [ADDR_W-1:0]        mem_addr,
   output logic [7:0]               mem_data_out,
   input  logic [7:0]               mem_data_in
);

   localparam int C_N2 = (DATA_BYTES < 2) ? DATA_BYTES : 2;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_XFER = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;

   logic [ADDR_W-1:0]   r_ra [NUM_RA];
   logic [ADDR_W-1:0]   r_base;
   logic [RAW-1:0]      r_sel;
   logic [1:0]          r_step;
   logic                r_store;
   logic                r_nib;
   logic                r_err;
   logic [3:0]          r_n;
   logic [3:0]          r_idx;
   logic [DW-1:0]       r_wdata;
   logic [DW-1:0]       r_buf;
   logic [DW-1:0]       r_rdata;

   logic [3:0]          w_n;
   logic                w_sel_ok;
   logic [ADDR_W-1:0]   w_sel_ra;
   logic                w_xfer;
   logic                w_last;
   logic [7:0]          w_wbyte;
   logic [7:0]          w_dout;
   logic [7:0]          w_rbyte;
   logic [DW-1:0]       w_buf_next;
   logic                w_int_upd;
   logic [ADDR_W-1:0]   w_ra_step;

   // Transfer length in bytes for the requested size
   always_comb begin
      w_n = 4'd1;
      case (req_size)
         2'd2:    w_n = 4'(C_N2);
         2'd3:    w_n = 4'(DATA_BYTES);
         default: w_n = 4'd1;
      endcase
   end

   // Index legality is checked in 32 bits so a non-power-of-two NUM_RA
   // correctly rejects the spare encodings.
   assign w_sel_ok = (32'(req_ra_sel) < 32'(NUM_RA));

   always_comb begin
      w_sel_ra = '0;
      for (int i = 0; i < NUM_RA; i++) begin
         if (req_ra_sel == RAW'(i)) w_sel_ra = r_ra[i];
      end
   end

   assign w_xfer = (r_state == S_XFER);
   assign w_last = (r_idx == (r_n - 4'd1));

   // Byte i of the latched store data; nibble stores clear the high half
   always_comb begin
      w_wbyte = '0;
      for (int b = 0; b < DATA_BYTES; b++) begin
         if (r_idx == 4'(b)) w_wbyte = r_wdata[b*8 +: 8];
      end
   end
   assign w_dout  = r_nib ? {4'h0, w_wbyte[3:0]} : w_wbyte;
   assign w_rbyte = r_nib ? {4'h0, mem_data_in[3:0]} : mem_data_in;

   // Load assembly buffer with the current bus byte merged in; it is
   // cleared on accept so bytes beyond the access size stay zero.
   always_comb begin
      w_buf_next = r_buf;
      for (int b = 0; b < DATA_BYTES; b++) begin
         if (r_idx == 4'(b)) w_buf_next[b*8 +: 8] = w_rbyte;
      end
   end

   // Post-update uses the latched base, so external writes to the same
   // register during the transfer never disturb the address sequence.
   assign w_ra_step = (r_step == 2'b10) ? (r_base - ADDR_W'(r_n))
                                        : (r_base + ADDR_W'(r_n));
   assign w_int_upd = w_xfer && w_last &&
                      ((r_step == 2'b01) || (r_step == 2'b10));

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_state_nxt;
   end

   // ------------------------------------------------------------------
   // FSM: next state and state-decoded outputs
   // ------------------------------------------------------------------
   always_comb begin
      w_state_nxt      = r_state;
      req_ready        = 1'b0;
      done             = 1'b0;
      err              = 1'b0;
      mem_enable_read  = 1'b0;
      mem_enable_write = 1'b0;
      mem_rw           = 1'b0;
      mem_addr         = '0;
      mem_data_out     = '0;
      case (r_state)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) w_state_nxt = w_sel_ok ? S_XFER : S_DONE;
         end
         S_XFER: begin
            mem_enable_read  = ~r_store;
            mem_enable_write = r_store;
            mem_rw           = r_store;
            mem_addr         = r_base + ADDR_W'(r_idx);
            mem_data_out     = r_store ? w_dout : 8'h00;
            if (w_last) w_state_nxt = S_DONE;
         end
         S_DONE: begin
            done        = 1'b1;
            err         = r_err;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Datapath and address registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_base  <= '0;
         r_sel   <= '0;
         r_step  <= '0;
         r_store <= 1'b0;
         r_nib   <= 1'b0;
         r_err   <= 1'b0;
         r_n     <= '0;
         r_idx   <= '0;
         r_wdata <= '0;
         r_buf   <= '0;
         r_rdata <= '0;
         for (int i = 0; i < NUM_RA; i++) r_ra[i] <= '0;
      end else begin
         // Internal post-update has priority over an external write
         for (int i = 0; i < NUM_RA; i++) begin
            if (w_int_upd && (r_sel == RAW'(i)))
               r_ra[i] <= w_ra_step;
            else if (ra_wr_en && (ra_wr_sel == RAW'(i)))
               r_ra[i] <= ra_wr_data;
         end

         case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  r_base  <= w_sel_ra;
                  r_sel   <= req_ra_sel;
                  r_step  <= req_step;
                  r_store <= req_store;
                  r_nib   <= (req_size == 2'd0);
                  r_err   <= ~w_sel_ok;
                  r_n     <= w_n;
                  r_idx   <= '0;
                  r_wdata <= req_wdata;
                  r_buf   <= '0;
               end
            end
            S_XFER: begin
               r_idx <= r_idx + 4'd1;
               if (!r_store) begin
                  r_buf <= w_buf_next;
                  if (w_last) r_rdata <= w_buf_next;
               end
            end
            default: ;
         endcase
      end
   end

   assign rdata = r_rdata;

   generate
      for (genvar g = 0; g < NUM_RA; g++) begin : g_ra_q
         assign ra_q[g*ADDR_W +: ADDR_W] = r_ra[g];
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_misao_xmem_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_misao_xmem_unit
// Purpose  : Self-checking bench for misao_xmem_unit (ADDR_W=15,
//            DATA_BYTES=4, NUM_RA=3). A byte memory serves the DUT bus; an
//            independent model predicts memory, address registers, rdata,
//            latency and bus address/data sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_misao_xmem_unit;

   localparam int AW  = 15;
   localparam int DB  = 4;
   localparam int NRA = 3;
   localparam int MSZ = 32768;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             req_valid = 1'b0;
   logic             req_ready;
   logic             req_store = 1'b0;
   logic [1:0]       req_size = '0;
   logic [1:0]       req_ra_sel = '0;
   logic [1:0]       req_step = '0;
   logic [31:0]      req_wdata = '0;
   logic [31:0]      rdata;
   logic             done;
   logic             err;
   logic             ra_wr_en = 1'b0;
   logic [1:0]       ra_wr_sel = '0;
   logic [AW-1:0]    ra_wr_data = '0;
   logic [NRA*AW-1:0] ra_q;
   logic             mem_enable_read;
   logic             mem_enable_write;
   logic             mem_rw;
   logic [AW-1:0]    mem_addr;
   logic [7:0]       mem_data_out;
   logic [7:0]       mem_data_in;

   int n_checks = 0;
   int n_fail   = 0;

   misao_xmem_unit #(.ADDR_W(AW), .DATA_BYTES(DB), .NUM_RA(NRA)) dut (
      .clk              (clk),
      .rst              (rst),
      .req_valid        (req_valid),
      .req_ready        (req_ready),
      .req_store        (req_store),
      .req_size         (req_size),
      .req_ra_sel       (req_ra_sel),
      .req_step         (req_step),
      .req_wdata        (req_wdata),
      .rdata            (rdata),
      .done             (done),
      .err              (err),
      .ra_wr_en         (ra_wr_en),
      .ra_wr_sel        (ra_wr_sel),
      .ra_wr_data       (ra_wr_data),
      .ra_q             (ra_q),
      .mem_enable_read  (mem_enable_read),
      .mem_enable_write (mem_enable_write),
      .mem_rw           (mem_rw),
      .mem_addr         (mem_addr),
      .mem_data_out     (mem_data_out),
      .mem_data_in      (mem_data_in)
   );

   always #5 clk = ~clk;

   // Bus-side memory
   logic [7:0] mem [MSZ];
   always @(posedge clk) if (mem_enable_write) mem[mem_addr] <= mem_data_out;
   assign mem_data_in = mem_enable_read ? mem[mem_addr] : 8'h00;

   // Reference state
   logic [7:0]  ref_mem [MSZ];
   int          ref_ra [NRA];
   logic [31:0] ref_rdata = '0;
   int          exp_addr[$];
   int          exp_dout[$];
   int          obs_addr[$];
   int          obs_dout[$];
   bit          obs_wr[$];

   // Results of the latest access
   int          o_lat, e_lat;
   bit          o_err, e_err, o_rdy;
   logic [31:0] o_rdata;

   function automatic int get_ra(input int i);
      logic [NRA*AW-1:0] v;
      v = ra_q;
      return int'(v[i*AW +: AW]);
   endfunction

   // Model of one access from the architectural rules
   task automatic model(input bit st, input int sz, input int sel, input int step,
                        input logic [31:0] wd, input bit xe, input int xs, input int xv);
      int n, base, a, b;
      logic [31:0] val;
      exp_addr.delete();
      exp_dout.delete();
      if (sel >= NRA) begin
         e_lat = 1; e_err = 1'b1;
         if (xe && xs < NRA) ref_ra[xs] = xv;
         return;
      end
      n    = (sz < 2) ? 1 : (sz == 2) ? 2 : DB;
      base = ref_ra[sel];
      val  = '0;
      for (int j = 0; j < n; j++) begin
         a = (base + j) % MSZ;
         exp_addr.push_back(a);
         if (st) begin
            b = (sz == 0) ? int'(wd & 32'hF) : int'((wd >> (8*j)) & 32'hFF);
            ref_mem[a] = 8'(b);
            exp_dout.push_back(b);
         end else begin
            b = int'(ref_mem[a]);
            if (sz == 0) b = b & 15;
            val = val | (32'(b) << (8*j));
         end
      end
      if (!st) ref_rdata = val;
      if (xe && xs < NRA) ref_ra[xs] = xv;
      if (step == 1)      ref_ra[sel] = (base + n) % MSZ;
      else if (step == 2) ref_ra[sel] = (base - n + MSZ) % MSZ;
      e_lat = n + 1; e_err = 1'b0;
   endtask

   // Drive one request (entered and left just after a rising edge)
   task automatic issue(input bit st, input int sz, input int sel, input int step,
                        input logic [31:0] wd, input bit xe, input int xs, input int xv);
      int c, cext;
      bit seen;
      obs_addr.delete(); obs_dout.delete(); obs_wr.delete();
      req_valid  = 1'b1;
      req_store  = st;
      req_size   = 2'(sz);
      req_ra_sel = 2'(sel);
      req_step   = 2'(step);
      req_wdata  = wd;
      @(negedge clk);
      o_rdy = req_ready;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      cext = (sel >= NRA) ? 0 : ((sz < 2) ? 0 : (sz == 2) ? 1 : DB - 1);
      o_lat = -1; o_err = 1'b0; o_rdata = 'x;
      seen = 1'b0;
      c = 0;
      while (!seen && c < 20) begin
         ra_wr_en   = xe && (c == cext);
         ra_wr_sel  = 2'(xs);
         ra_wr_data = AW'(xv);
         @(negedge clk);
         if (mem_enable_read || mem_enable_write) begin
            obs_addr.push_back(int'(mem_addr));
            obs_dout.push_back(int'(mem_data_out));
            obs_wr.push_back(mem_enable_write && mem_rw);
         end
         if (done) begin
            seen    = 1'b1;
            o_lat   = c + 1;
            o_err   = err;
            o_rdata = rdata;
         end
         @(posedge clk);
         #1;
         ra_wr_en = 1'b0;
         c++;
      end
   endtask

   task automatic acc(input bit st, input int sz, input int sel, input int step,
                      input logic [31:0] wd, input bit xe = 0, input int xs = 0,
                      input int xv = 0);
      model(st, sz, sel, step, wd, xe, xs, xv);
      issue(st, sz, sel, step, wd, xe, xs, xv);
   endtask

   task automatic set_ra(input int sel, input int val);
      ra_wr_en   = 1'b1;
      ra_wr_sel  = 2'(sel);
      ra_wr_data = AW'(val);
      @(posedge clk);
      #1;
      ra_wr_en = 1'b0;
      ref_ra[sel] = val;
   endtask

   // ---------------------------------------------------------------
   task automatic test_reset;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if ({mem_enable_read, mem_enable_write, mem_rw, done, err} !== 5'b0) begin
         n_fail++; $display("FAIL reset_strobes got=%b want=00000",
                            {mem_enable_read, mem_enable_write, mem_rw, done, err});
      end
      n_checks++;
      if (mem_addr !== '0 || mem_data_out !== '0) begin
         n_fail++; $display("FAIL reset_bus addr=%h dout=%h want 0", mem_addr, mem_data_out);
      end
      n_checks++;
      if (rdata !== '0 || ra_q !== '0) begin
         n_fail++; $display("FAIL reset_regs rdata=%h ra_q=%h want 0", rdata, ra_q);
      end
      n_checks++;
      if (req_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_ready got=%b want=1", req_ready);
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_nibble_byte;
      set_ra(0, 'h80);
      acc(1, 0, 0, 1, 32'h5);
      n_checks++;
      if (o_lat !== 2 || mem['h80] !== 8'h05) begin
         n_fail++; $display("FAIL nib_store lat=%0d mem80=%h want 2/05", o_lat, mem['h80]);
      end
      acc(1, 1, 0, 0, 32'h03);
      n_checks++;
      if (o_lat !== 2 || mem['h81] !== 8'h03) begin
         n_fail++; $display("FAIL byte_store lat=%0d mem81=%h want 2/03", o_lat, mem['h81]);
      end
      acc(0, 0, 0, 0, 32'h0);
      n_checks++;
      if (o_lat !== 2 || o_rdata !== 32'h3 || get_ra(0) !== 'h81) begin
         n_fail++; $display("FAIL nib_load lat=%0d rdata=%h ra0=%h want 2/3/81",
                            o_lat, o_rdata, get_ra(0));
      end
   endtask

   task automatic test_word;
      set_ra(1, 'h90);
      acc(1, 2, 1, 1, 32'h1234);
      n_checks++;
      if (mem['h90] !== 8'h34 || mem['h91] !== 8'h12 || get_ra(1) !== 'h92 || o_lat !== 3) begin
         n_fail++; $display("FAIL word_store m90=%h m91=%h ra1=%h lat=%0d want 34/12/92/3",
                            mem['h90], mem['h91], get_ra(1), o_lat);
      end
      set_ra(1, 'h90);
      acc(0, 2, 1, 2, 32'h0);
      n_checks++;
      if (o_rdata !== 32'h1234 || get_ra(1) !== 'h8E || o_lat !== 3) begin
         n_fail++; $display("FAIL word_load rdata=%h ra1=%h lat=%0d want 1234/8e/3",
                            o_rdata, get_ra(1), o_lat);
      end
   endtask

   task automatic test_wrap;
      set_ra(0, 'h7FFF);
      acc(1, 2, 0, 1, 32'hBEEF);
      n_checks++;
      if (mem['h7FFF] !== 8'hEF || mem[0] !== 8'hBE || get_ra(0) !== 1) begin
         n_fail++; $display("FAIL wrap_store m7fff=%h m0=%h ra0=%h want ef/be/1",
                            mem['h7FFF], mem[0], get_ra(0));
      end
      set_ra(0, 0);
      acc(0, 1, 0, 2, 32'h0);
      n_checks++;
      if (get_ra(0) !== 'h7FFF || o_rdata !== 32'hBE) begin
         n_fail++; $display("FAIL wrap_dec ra0=%h rdata=%h want 7fff/be", get_ra(0), o_rdata);
      end
   endtask

   task automatic test_wide;
      for (int j = 0; j < 4; j++) begin
         mem['h40 + j]     = 8'(8'h11 * (j + 1));
         ref_mem['h40 + j] = 8'(8'h11 * (j + 1));
      end
      set_ra(2, 'h40);
      acc(0, 3, 2, 0, 32'h0);
      n_checks++;
      if (o_rdata !== 32'h44332211 || o_lat !== 5) begin
         n_fail++; $display("FAIL wide_load rdata=%h lat=%0d want 44332211/5", o_rdata, o_lat);
      end
      acc(0, 2, 2, 0, 32'h0);
      n_checks++;
      if (o_rdata !== 32'h00002211 || o_lat !== 3) begin
         n_fail++; $display("FAIL size2_load rdata=%h lat=%0d want 00002211/3", o_rdata, o_lat);
      end
   endtask

   task automatic test_collision;
      set_ra(0, 'h80);
      acc(1, 0, 0, 1, 32'h7, 1, 0, 'h100);
      n_checks++;
      if (get_ra(0) !== 'h81) begin
         n_fail++; $display("FAIL collide_same ra0=%h want 81", get_ra(0));
      end
      set_ra(1, 'h50);
      acc(1, 0, 0, 1, 32'h9, 1, 1, 'h100);
      n_checks++;
      if (get_ra(1) !== 'h100 || get_ra(0) !== 'h82) begin
         n_fail++; $display("FAIL collide_other ra1=%h ra0=%h want 100/82", get_ra(1), get_ra(0));
      end
   endtask

   task automatic test_illegal;
      acc(0, 1, 3, 1, 32'h0);
      n_checks++;
      if (o_err !== 1'b1 || o_lat !== 1 || obs_addr.size() != 0) begin
         n_fail++; $display("FAIL illegal err=%b lat=%0d strobes=%0d want 1/1/0",
                            o_err, o_lat, obs_addr.size());
      end
      n_checks++;
      if (o_rdata !== ref_rdata || get_ra(0) !== ref_ra[0] ||
          get_ra(1) !== ref_ra[1] || get_ra(2) !== ref_ra[2]) begin
         n_fail++; $display("FAIL illegal_state rdata=%h want %h ra_q=%h",
                            o_rdata, ref_rdata, ra_q);
      end
   endtask

   task automatic test_back_to_back;
      set_ra(2, 'h40);
      acc(0, 1, 2, 1, 32'h0);
      acc(0, 1, 2, 1, 32'h0);
      n_checks++;
      if (o_rdy !== 1'b1 || o_lat !== 2 || o_rdata !== 32'h22 || get_ra(2) !== 'h42) begin
         n_fail++; $display("FAIL back_to_back rdy=%b lat=%0d rdata=%h ra2=%h want 1/2/22/42",
                            o_rdy, o_lat, o_rdata, get_ra(2));
      end
   endtask

   task automatic test_reset_mid;
      logic [7:0] old1;
      set_ra(1, 'h200);
      old1 = mem['h201];
      req_valid = 1'b1; req_store = 1'b1; req_size = 2'd2;
      req_ra_sel = 2'd1; req_step = 2'd1; req_wdata = 32'hA55A;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      rst = 1'b0;
      @(posedge clk);
      #1;
      n_checks++;
      if ({mem_enable_read, mem_enable_write, mem_rw, done, err} !== 5'b0 ||
          mem_addr !== '0 || mem_data_out !== '0 || req_ready !== 1'b1) begin
         n_fail++; $display("FAIL mid_reset_bus strobes=%b addr=%h dout=%h rdy=%b",
                            {mem_enable_read, mem_enable_write, mem_rw, done, err},
                            mem_addr, mem_data_out, req_ready);
      end
      n_checks++;
      if (mem['h200] !== 8'h5A || mem['h201] !== old1 || ra_q !== '0 || rdata !== '0) begin
         n_fail++; $display("FAIL mid_reset_state m200=%h m201=%h(want %h) ra_q=%h rdata=%h",
                            mem['h200], mem['h201], old1, ra_q, rdata);
      end
      rst = 1'b1;
      ref_mem['h200] = 8'h5A;
      for (int i = 0; i < NRA; i++) ref_ra[i] = 0;
      ref_rdata = '0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_random;
      int sz, sel, step, xs, xv;
      bit st, xe;
      logic [31:0] wd;
      for (int it = 0; it < 60; it++) begin
         if ($urandom_range(0, 4) == 0) set_ra($urandom_range(0, NRA-1), $urandom_range(0, MSZ-1));
         st   = 1'($urandom_range(0, 1));
         sz   = $urandom_range(0, 3);
         sel  = $urandom_range(0, 3);
         step = $urandom_range(0, 3);
         wd   = $urandom;
         xe   = ($urandom_range(0, 3) == 0);
         xs   = $urandom_range(0, 3);
         xv   = $urandom_range(0, MSZ-1);
         acc(st, sz, sel, step, wd, xe, xs, xv);
         n_checks++;
         if (o_lat !== e_lat || o_err !== e_err || o_rdata !== ref_rdata) begin
            n_fail++; $display("FAIL rnd%0d lat=%0d/%0d err=%b/%b rdata=%h/%h",
                               it, o_lat, e_lat, o_err, e_err, o_rdata, ref_rdata);
         end
         for (int i = 0; i < NRA; i++) begin
            n_checks++;
            if (get_ra(i) !== ref_ra[i]) begin
               n_fail++; $display("FAIL rnd%0d_ra%0d got=%h want=%h", it, i, get_ra(i), ref_ra[i]);
            end
         end
         n_checks++;
         if (obs_addr.size() != exp_addr.size()) begin
            n_fail++; $display("FAIL rnd%0d_nstrobe got=%0d want=%0d",
                               it, obs_addr.size(), exp_addr.size());
         end else begin
            for (int j = 0; j < exp_addr.size(); j++) begin
               n_checks++;
               if (obs_addr[j] != exp_addr[j] || obs_wr[j] != st ||
                   (st && obs_dout[j] != exp_dout[j]) ||
                   mem[exp_addr[j]] !== ref_mem[exp_addr[j]]) begin
                  n_fail++; $display("FAIL rnd%0d_bus%0d addr=%h/%h wr=%b dout=%h mem=%h/%h",
                                     it, j, obs_addr[j], exp_addr[j], obs_wr[j], obs_dout[j],
                                     mem[exp_addr[j]], ref_mem[exp_addr[j]]);
               end
            end
         end
      end
   endtask

   initial begin
      logic [7:0] b;
      for (int i = 0; i < MSZ; i++) begin
         b = 8'($urandom);
         mem[i]     = b;
         ref_mem[i] = b;
      end
      for (int i = 0; i < NRA; i++) ref_ra[i] = 0;
      test_reset;
      test_nibble_byte;
      test_word;
      test_wrap;
      test_wide;
      test_collision;
      test_illegal;
      test_back_to_back;
      test_reset_mid;
      test_random;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/misao_xmem_unit.md
# misao_xmem_unit

Parametrised XMEM load/store unit for the MISA-O core. It sits between the execute stage and the shared byte-wide memory bus. It holds NUM_RA address registers and sequences nibble, byte or multi-byte little-endian transfers one byte per cycle. It applies optional post-increment or post-decrement by the access size, and reports completion with a one-cycle `done` pulse.

## Interface
- `ADDR_W`, 15: memory address width in bits.
- `DATA_BYTES`, 2: widest access in bytes (1..8); data ports are 8*DATA_BYTES wide.
- `NUM_RA`, 2: number of address registers (1..8); RAW = clog2(NUM_RA), min 1.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `req_valid`  in  1  request strobe.
- `req_ready`  out  1  high when IDLE.
- `req_store`  in  1  1 = store, 0 = load.
- `req_size`  in  2  0 = nibble, 1 = byte, 2 = two bytes, 3 = DATA_BYTES bytes.
- `req_ra_sel`  in  RAW  address register index.
- `req_step`  in  2  00 = none, 01 = post-inc, 10 = post-dec, 11 = none.
- `req_wdata`  in  8*DATA_BYTES  store data, LSB first.
- `rdata`  out  8*DATA_BYTES  load result, zero-extended.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  one-cycle pulse for an illegal `req_ra_sel`.
- `ra_wr_en`  in  1  external address-register write enable.
- `ra_wr_sel`  in  RAW  external write index.
- `ra_wr_data`  in  ADDR_W  external write value.
- `ra_q`  out  NUM_RA*ADDR_W  all address registers, RA0 in the LSBs.
- `mem_enable_read`  out  1  read strobe; `mem_data_in` is valid in the same cycle.
- `mem_enable_write`  out  1  write strobe; memory captures on the rising edge.
- `mem_rw`  out  1  1 on write cycles, else 0.
- `mem_addr`  out  ADDR_W  byte address.
- `mem_data_out`  out  8  write byte.
- `mem_data_in`  in  8  read byte.

## Operation
- Size n: nibble → 1, byte → 1, two bytes → min(2, DATA_BYTES), size 3 → DATA_BYTES.
- FSM IDLE → XFER → DONE → IDLE.
- IDLE: `req_ready` = 1. On `req_valid`, latch the request, set base = RA[sel] and index i = 0, then go to XFER.
- Illegal index (sel ≥ NUM_RA): no bus activity, go to DONE with `err` = 1, no RA change, `rdata` unchanged.
- XFER, cycle i: `mem_addr` = (base + i) mod 2^ADDR_W.
  - Store: drive byte i of wdata, with strobe and `mem_rw` = 1. A nibble store drives {4'h0, wdata[3:0]}.
  - Load: read strobe; capture `mem_data_in` into byte i. A nibble load keeps only [3:0].
  - After i = n-1, go to DONE.
- DONE: `done` = 1.
  - Load: `rdata` updates on entry to DONE; unused upper bytes are 0.
  - Store: `rdata` keeps its prior value.
- RA post-update is written on the XFER→DONE edge: RA[sel] = base ± n, mod 2^ADDR_W, wrapping both ways.
- Little-endian: byte 0 is at base.
- External RA write: accepted in any state.
  - If it collides with the internal post-update on the same index in the same cycle, the internal update wins.
  - A different index is written normally.
  - A write to RA[sel] during XFER does not change the latched base.
- `req_valid` outside IDLE is ignored; no queueing.
- Reset (`rst` = 0 at an edge), including mid-transfer: state → IDLE, all RA = 0, `rdata` = 0. From the next cycle, no strobes.

## Timing
- Request accepted at edge k. XFER cycles are k..k+n-1. `done` is high in cycle k+n. `req_ready` is high again at k+n+1.
- Latency is n+1 cycles per access: 2 for nibble/byte, 3 for a word.
- Back-to-back: the next request can be accepted at the edge that ends cycle k+n+1 (IDLE).
- Bus outputs are registered or decoded from state, and are stable for a whole cycle.
- Reset values: `mem_enable_read` = 0, `mem_enable_write` = 0, `mem_rw` = 0, `mem_addr` = 0, `mem_data_out` = 0, `rdata` = 0, `done` = 0, `err` = 0, `ra_q` = 0, `req_ready` = 1.
- Outside XFER, `mem_addr` and `mem_data_out` are 0.

## Test plan
- RA0 = 0x0080. Nibble store 0x5 post-inc, then byte store 0x03 no-step, then nibble load → MEM[80] = 05, MEM[81] = 03, RA0 = 0x0081, `rdata` = 0x0003; each access shows `done` 2 cycles after accept.
- RA1 = 0x0090. Word store 0x1234 post-inc → MEM[90] = 34, MEM[91] = 12, RA1 = 0x0092. Then word load post-dec with RA1 = 0x0090 → `rdata` = 0x1234, RA1 = 0x008E, `done` 3 cycles after accept.
- Wrap: RA0 = 0x7FFF, word store 0xBEEF post-inc → MEM[7FFF] = EF, MEM[0000] = BE, RA0 = 0x0001. Then RA0 = 0x0000, byte load post-dec → RA0 = 0x7FFF.
- DATA_BYTES = 4, size 3 load from 0x40..0x43 holding 11 22 33 44 → `rdata` = 0x44332211 after 5 cycles. Size 2 on the same data → `rdata` = 0x00002211.
- Collision: external write RA0 = 0x0100 on the same cycle as the RA0 post-inc to 0x0081 → RA0 = 0x0081. Same-cycle external write to RA1 = 0x0100 → applied.
- Reset after the first byte of a word store → only MEM[base] is written, no further strobes, all outputs at reset values. Illegal `req_ra_sel` with NUM_RA = 3 → `err` and `done` together 1 cycle after accept, no bus activity.
